// File: rtl/rx_pkg.sv
// rx_pkg: shared event codes, SFD chip pattern and buffer depth for the VLC receiver
package rx_pkg;
  typedef enum logic [2:0] {
    RX_EVENT_NONE = 3'd0,
    RX_EVENT_SFD  = 3'd1,
    RX_EVENT_PHR  = 3'd2,
    RX_EVENT_END  = 3'd3,
    RX_EVENT_ERR  = 3'd4
  } rx_event_e;
  localparam logic [7:0] RX_SFD = 8'hA7;
  localparam int RX_BUF_DEPTH = 128;
  // Manchester-encodes a byte LSB first; chip 2i is sent before chip 2i+1, bit 1 -> chips 1,0
  function automatic logic [15:0] manch_enc(input logic [7:0] b);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c[2*i]   = b[i];
      c[2*i+1] = ~b[i];
    end
    return c;
  endfunction
  localparam logic [15:0] RX_SFD_CHIPS = manch_enc(RX_SFD);
endpackage

// File: rtl/rx_chip_dec.sv
// rx_chip_dec: sample clock divider, slicer and chip phase tracker producing decided chips
module rx_chip_dec
  import rx_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int CLK_DIV = 8,
  parameter int SPC     = 4,
  parameter int THRESH  = 512
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] rx_i,
  output logic             smp_clk_o,
  output logic             chip_o,
  output logic             chip_v_o
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(SPC);
  logic [DW-1:0] div_q, div_d;
  logic [PW-1:0] phase_q, phase_d;
  logic sclk_q, sclk_d, smp_q, smp_d, smp_v_q, prev_q, prev_d;
  logic chip_q, chip_d, chip_v_q, chip_v_d, div_end;
  // Divider sets the sample clock mid-period and captures the sliced sample on its falling edge;
  // a slicer transition realigns the chip phase and the chip is decided mid-chip
  always_comb begin
    div_end  = div_q == DW'(CLK_DIV - 1);
    div_d    = div_end ? '0 : div_q + 1'b1;
    sclk_d   = div_end ? 1'b0 : (div_q == DW'(CLK_DIV / 2 - 1)) ? 1'b1 : sclk_q;
    smp_d    = div_end ? (rx_i >= WIDTH'(THRESH)) : smp_q;
    phase_d  = !smp_v_q ? phase_q :
               (smp_q != prev_q || phase_q == PW'(SPC - 1)) ? '0 : phase_q + 1'b1;
    prev_d   = smp_v_q ? smp_q : prev_q;
    chip_v_d = smp_v_q && phase_d == PW'(SPC / 2);
    chip_d   = chip_v_d ? smp_q : chip_q;
  end
  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= '0;
      sclk_q   <= 1'b0;
      smp_q    <= 1'b0;
      smp_v_q  <= 1'b0;
      prev_q   <= 1'b0;
      phase_q  <= '0;
      chip_q   <= 1'b0;
      chip_v_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      smp_q    <= smp_d;
      smp_v_q  <= div_end;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      chip_q   <= chip_d;
      chip_v_q <= chip_v_d;
    end
  end
  assign smp_clk_o = sclk_q;
  assign chip_o    = chip_q;
  assign chip_v_o  = chip_v_q;
endmodule

// File: rtl/vlc_rx.sv
// vlc_rx: VLC baseband receiver; SFD hunt, Manchester bit pairing, framing FSM and frame buffer
module vlc_rx
  import rx_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int CLK_DIV = 8,
  parameter int SPC     = 4,
  parameter int THRESH  = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_rx_in,
  input  logic [6:0]       i_buf_r_addr,
  output logic [7:0]       o_buf_r_byte,
  output logic [2:0]       o_ev,
  output logic             o_ev_sig,
  output logic             o_clk
);
  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_PHR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  logic        chip, chip_v, wr_en;
  logic [1:0]  state_q, state_d;
  logic [15:0] sr_q, sr_d, sr_shift;
  logic        half_q, half_d, first_q, first_d, ev_sig_q;
  logic [2:0]  bcnt_q, bcnt_d, pend_q, pend_d, ev_q;
  logic [7:0]  byte_q, byte_d, byte_nxt;
  logic [6:0]  len_q, len_d, addr_q, addr_d;
  logic [7:0]  mem [RX_BUF_DEPTH];
  rx_chip_dec #(
    .WIDTH  (WIDTH),
    .CLK_DIV(CLK_DIV),
    .SPC    (SPC),
    .THRESH (THRESH)
  ) u_chip_dec (
    .clk_i    (clk),
    .rst_ni   (reset),
    .rx_i     (i_rx_in),
    .smp_clk_o(o_clk),
    .chip_o   (chip),
    .chip_v_o (chip_v)
  );
  // Framing FSM: hunt for the SFD chip pattern, then pair chips into bits and bits into bytes
  always_comb begin
    byte_nxt = {first_q, byte_q[7:1]};
    sr_shift = {chip, sr_q[15:1]};
    wr_en    = i_enable && chip_v && state_q != ST_HUNT && half_q && first_q != chip && bcnt_q == 3'd7;
    state_d  = state_q;
    sr_d     = sr_q;
    half_d   = half_q;
    first_d  = first_q;
    bcnt_d   = bcnt_q;
    byte_d   = byte_q;
    len_d    = len_q;
    addr_d   = addr_q;
    pend_d   = RX_EVENT_NONE;
    if (!i_enable) begin
      state_d = ST_HUNT;
      sr_d    = '0;
      half_d  = 1'b0;
      bcnt_d  = '0;
    end else if (chip_v && state_q == ST_HUNT) begin
      sr_d = sr_shift;
      if (sr_shift == RX_SFD_CHIPS) begin
        state_d = ST_PHR;
        sr_d    = '0;
        half_d  = 1'b0;
        bcnt_d  = '0;
        addr_d  = '0;
        pend_d  = RX_EVENT_SFD;
      end
    end else if (chip_v && !half_q) begin
      first_d = chip;
      half_d  = 1'b1;
    end else if (chip_v && first_q == chip) begin
      state_d = ST_HUNT;
      half_d  = 1'b0;
      pend_d  = RX_EVENT_ERR;
    end else if (chip_v) begin
      half_d = 1'b0;
      byte_d = byte_nxt;
      bcnt_d = bcnt_q + 3'd1;
      if (bcnt_q == 3'd7 && state_q == ST_PHR) begin
        len_d   = byte_nxt[6:0];
        addr_d  = 7'd1;
        state_d = byte_nxt[6:0] == 7'd0 ? ST_HUNT : ST_PAY;
        pend_d  = byte_nxt[6:0] == 7'd0 ? RX_EVENT_ERR : RX_EVENT_PHR;
      end else if (bcnt_q == 3'd7) begin
        addr_d  = addr_q + 7'd1;
        state_d = addr_q == len_q ? ST_HUNT : ST_PAY;
        pend_d  = addr_q == len_q ? RX_EVENT_END : RX_EVENT_NONE;
      end
    end
  end
  // State registers; events are held one cycle so the completing byte is already in the buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_HUNT;
      sr_q     <= '0;
      half_q   <= 1'b0;
      first_q  <= 1'b0;
      bcnt_q   <= '0;
      byte_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      pend_q   <= RX_EVENT_NONE;
      ev_q     <= RX_EVENT_NONE;
      ev_sig_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      half_q   <= half_d;
      first_q  <= first_d;
      bcnt_q   <= bcnt_d;
      byte_q   <= byte_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      ev_sig_q <= pend_q != RX_EVENT_NONE;
      if (pend_q != RX_EVENT_NONE) ev_q <= pend_q;
    end
  end
  // Frame buffer write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= byte_nxt;
  end
  assign o_buf_r_byte = mem[i_buf_r_addr];
  assign o_ev         = ev_q;
  assign o_ev_sig     = ev_sig_q;
endmodule

// File: tb/tb_vlc_rx.sv
// tb_vlc_rx: scoreboard bench driving Manchester sample streams into vlc_rx
`timescale 1ns/1ps
module tb_vlc_rx;
  import rx_pkg::*;
  logic       clk = 1'b0, reset = 1'b0, i_enable = 1'b0;
  logic [9:0] i_rx_in = '0;
  logic [6:0] i_buf_r_addr = '0;
  logic [7:0] o_buf_r_byte;
  logic [2:0] o_ev;
  logic       o_ev_sig, o_clk;
  int tests = 0, fails = 0;
  logic [9:0] sq[$];
  logic [2:0] ev_q[$];
  always #5 clk = ~clk;
  vlc_rx dut (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (i_enable),
    .i_rx_in     (i_rx_in),
    .i_buf_r_addr(i_buf_r_addr),
    .o_buf_r_byte(o_buf_r_byte),
    .o_ev        (o_ev),
    .o_ev_sig    (o_ev_sig),
    .o_clk       (o_clk)
  );
  initial forever begin
    @(posedge o_clk);
    i_rx_in = sq.size() != 0 ? sq.pop_front() : 10'd0;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic push_chip(input logic c);
    for (int i = 0; i < 4; i++)
      sq.push_back(i == 2 ? (c ? 10'd512 : 10'd511) :
                   c ? 10'($urandom_range(1023, 512)) : 10'($urandom_range(511, 0)));
  endtask
  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      push_chip(b[i]);
      push_chip(~b[i]);
    end
  endtask
  task automatic push_head(input int pre, input logic [7:0] phr);
    repeat (pre) push_byte(8'h55);
    push_byte(8'hA7);
    push_byte(phr);
  endtask
  task automatic wait_ev(input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = o_ev_sig;
    end
  endtask
  task automatic count_ev(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (o_ev_sig) n++;
    end
  endtask
  task automatic test_reset;
    int n;
    reset = 1'b0;
    i_enable = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (o_clk !== 1'b0) begin fails++; $display("FAIL rst_oclk got=%0b exp=0", o_clk); end
    tests++; if (o_ev !== 3'd0) begin fails++; $display("FAIL rst_ev got=%0d exp=0", o_ev); end
    tests++; if (o_ev_sig !== 1'b0) begin fails++; $display("FAIL rst_evsig got=%0b exp=0", o_ev_sig); end
    reset = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_clk !== 1'b1 && n < 20);
    tests++; if (n != 4) begin fails++; $display("FAIL oclk_first_rise got=%0d exp=4", n); end
    n = 0;
    do begin @(negedge clk); n++; end while (o_clk !== 1'b0 && n < 20);
    tests++; if (n != 4) begin fails++; $display("FAIL oclk_high got=%0d exp=4", n); end
    n = 0;
    do begin @(negedge clk); n++; end while (o_clk !== 1'b1 && n < 20);
    tests++; if (n != 4) begin fails++; $display("FAIL oclk_low got=%0d exp=4", n); end
    count_ev(1500, n);
    tests++; if (n != 0) begin fails++; $display("FAIL idle_events got=%0d exp=0", n); end
  endtask
  task automatic test_basic;
    logic got;
    logic [2:0] exp;
    logic [31:0] want;
    want = 32'h33221103;
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    ev_q.push_back(RX_EVENT_END);
    push_head(4, 8'h03);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL basic_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
      if (exp == RX_EVENT_PHR) begin
        i_buf_r_addr = 7'd0;
        #1;
        tests++; if (o_buf_r_byte !== 8'h03) begin fails++; $display("FAIL basic_phr_buf0 got=%h exp=03", o_buf_r_byte); end
        @(negedge clk);
        tests++;
        if (o_ev_sig !== 1'b0 || o_ev !== RX_EVENT_PHR) begin
          fails++; $display("FAIL basic_strobe sig=%0b ev=%0d exp sig=0 ev=2", o_ev_sig, o_ev);
        end
      end
    end
    for (int a = 0; a < 4; a++) begin
      i_buf_r_addr = 7'(a);
      #1;
      tests++;
      if (o_buf_r_byte !== want[8*a +: 8]) begin
        fails++; $display("FAIL basic_buf[%0d] got=%h exp=%h", a, o_buf_r_byte, want[8*a +: 8]);
      end
    end
  endtask
  task automatic test_long;
    logic got;
    logic [2:0] exp;
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    ev_q.push_back(RX_EVENT_END);
    push_head(1, 8'hFF);
    for (int k = 0; k < 127; k++) push_byte(8'(k));
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(80000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL long_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    i_buf_r_addr = 7'd0;   #1;
    tests++; if (o_buf_r_byte !== 8'hFF) begin fails++; $display("FAIL long_buf0 got=%h exp=ff", o_buf_r_byte); end
    i_buf_r_addr = 7'd1;   #1;
    tests++; if (o_buf_r_byte !== 8'h00) begin fails++; $display("FAIL long_buf1 got=%h exp=00", o_buf_r_byte); end
    i_buf_r_addr = 7'd64;  #1;
    tests++; if (o_buf_r_byte !== 8'h3F) begin fails++; $display("FAIL long_buf64 got=%h exp=3f", o_buf_r_byte); end
    i_buf_r_addr = 7'd127; #1;
    tests++; if (o_buf_r_byte !== 8'h7E) begin fails++; $display("FAIL long_buf127 got=%h exp=7e", o_buf_r_byte); end
  endtask
  task automatic test_err;
    logic got;
    logic [2:0] exp;
    int n;
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    ev_q.push_back(RX_EVENT_ERR);
    push_head(1, 8'h04);
    push_byte(8'h11);
    push_chip(1'b0); push_chip(1'b1);
    push_chip(1'b1); push_chip(1'b0);
    push_chip(1'b1); push_chip(1'b1);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL err_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    i_buf_r_addr = 7'd1; #1;
    tests++; if (o_buf_r_byte !== 8'h11) begin fails++; $display("FAIL err_buf1 got=%h exp=11", o_buf_r_byte); end
    count_ev(300, n);
    tests++; if (n != 0) begin fails++; $display("FAIL err_no_end got=%0d exp=0", n); end
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    ev_q.push_back(RX_EVENT_END);
    push_head(1, 8'h02);
    push_byte(8'hAB);
    push_byte(8'hCD);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL recover_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    i_buf_r_addr = 7'd0; #1;
    tests++; if (o_buf_r_byte !== 8'h02) begin fails++; $display("FAIL recover_buf0 got=%h exp=02", o_buf_r_byte); end
    i_buf_r_addr = 7'd1; #1;
    tests++; if (o_buf_r_byte !== 8'hAB) begin fails++; $display("FAIL recover_buf1 got=%h exp=ab", o_buf_r_byte); end
    i_buf_r_addr = 7'd2; #1;
    tests++; if (o_buf_r_byte !== 8'hCD) begin fails++; $display("FAIL recover_buf2 got=%h exp=cd", o_buf_r_byte); end
  endtask
  task automatic test_phr0;
    logic got;
    logic [2:0] exp;
    int n;
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_ERR);
    push_head(1, 8'h00);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL phr0_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    i_buf_r_addr = 7'd0; #1;
    tests++; if (o_buf_r_byte !== 8'h00) begin fails++; $display("FAIL phr0_buf0 got=%h exp=00", o_buf_r_byte); end
    count_ev(300, n);
    tests++; if (n != 0) begin fails++; $display("FAIL phr0_quiet got=%0d exp=0", n); end
  endtask
  task automatic test_reset_mid;
    logic got;
    logic [2:0] exp;
    int n;
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    push_head(1, 8'h05);
    repeat (3) push_byte(8'h9C);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL rstmid_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (o_ev !== 3'd0 || o_ev_sig !== 1'b0 || o_clk !== 1'b0) begin
      fails++; $display("FAIL rstmid_async ev=%0d sig=%0b oclk=%0b exp all 0", o_ev, o_ev_sig, o_clk);
    end
    sq.delete();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    count_ev(800, n);
    tests++; if (n != 0) begin fails++; $display("FAIL rstmid_quiet got=%0d exp=0", n); end
  endtask
  task automatic test_enable;
    logic got;
    logic [2:0] exp;
    int n;
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    push_head(1, 8'h03);
    repeat (3) push_byte(8'h6D);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL en_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    repeat (150) @(negedge clk);
    i_enable = 1'b0;
    sq.delete();
    repeat (100) @(negedge clk);
    i_enable = 1'b1;
    count_ev(600, n);
    tests++; if (n != 0) begin fails++; $display("FAIL en_abort_quiet got=%0d exp=0", n); end
    ev_q.push_back(RX_EVENT_SFD);
    ev_q.push_back(RX_EVENT_PHR);
    ev_q.push_back(RX_EVENT_END);
    push_head(1, 8'h01);
    push_byte(8'h5A);
    while (ev_q.size() != 0) begin
      exp = ev_q.pop_front();
      wait_ev(4000, got);
      tests++;
      if (!got || o_ev !== exp) begin fails++; $display("FAIL en_fresh_ev sig=%0b got=%0d exp=%0d", got, o_ev, exp); end
    end
    i_buf_r_addr = 7'd1; #1;
    tests++; if (o_buf_r_byte !== 8'h5A) begin fails++; $display("FAIL en_buf1 got=%h exp=5a", o_buf_r_byte); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_long();
    test_err();
    test_phr0();
    test_reset_mid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vlc_rx.md
# vlc_rx

Baseband receiver for the VLC link. It slices 10-bit photodiode ADC samples and Manchester-decodes the chip stream. It finds the start-of-frame delimiter and stores the length byte (PHR) and payload in an internal 128-byte buffer. It reports progress to the host controller through one-cycle event strobes, and provides the sample clock that paces the ADC/sample source.

## Interface
- `WIDTH`, 10: ADC sample width.
- `CLK_DIV`, 8: `clk` cycles per sample period (even, ≥4).
- `SPC`, 4: samples per Manchester chip.
- `THRESH`, 512: slicer threshold; a sample ≥ `THRESH` is chip 1.
- `clk` input, 1: the single system clock.
- `reset` input, 1: asynchronous, active-low.
- `i_enable` input, 1: receiver enable; 0 holds the decoder in HUNT.
- `i_rx_in` input, `WIDTH`: ADC sample, updated by the source on rising `o_clk`.
- `i_buf_r_addr` input, 7: buffer read address.
- `o_buf_r_byte` output, 8: buffer byte at `i_buf_r_addr`.
- `o_ev` output, 3: event code, defined in `rx_pkg`.
  - 0 = NONE, 1 = SFD, 2 = PHR, 3 = END, 4 = ERR.
- `o_ev_sig` output, 1: one-`clk` strobe marking a new `o_ev`.
- `o_clk` output, 1: sample clock, 50 % duty, period `CLK_DIV`.

## Operation
- Reset values:
  - `o_clk` = 0, `o_ev` = NONE, `o_ev_sig` = 0.
  - State = HUNT; all counters and shift registers are 0.
  - Buffer contents are unspecified.
- Sample capture:
  - `i_rx_in` is captured on the `clk` edge at which the divider produces the falling edge of `o_clk` (mid-period, stable).
  - The slicer compares the captured value with `THRESH`.
- Chip timing:
  - A phase counter 0..`SPC`-1 advances per sample.
  - A slicer transition forces phase to 0.
  - The chip is decided at phase `SPC`/2.
- HUNT:
  - Decided chips shift into a 16-chip register.
  - A match with Manchester-encoded SFD 0xA7 (bit 1 = chips 1,0; bit 0 = chips 0,1; LSB first) moves to PHR and emits SFD.
  - Chip pairing is fixed from that point.
- Bit decoding: chip pair 10 → 1, 01 → 0, 00 or 11 → ERR and return to HUNT. Bytes are LSB first.
- PHR:
  - The 8 bits are written to buffer[0].
  - `len` = bits[6:0].
  - `len` = 0 → ERR and return to HUNT. Otherwise emit PHR and enter PAYLOAD.
- PAYLOAD:
  - Byte k (1..`len`) is written to buffer[k].
  - After buffer[`len`] is written, emit END and return to HUNT.
- Events:
  - Each event raises `o_ev_sig` for exactly one `clk` and updates `o_ev`.
  - `o_ev` holds its code until the next event.
- Buffer:
  - Single write port, internal.
  - Asynchronous read: `o_buf_r_byte` = mem[`i_buf_r_addr`] combinationally.
  - Written only during PHR/PAYLOAD; contents persist until overwritten by the next frame.
- `i_enable` = 0 aborts the current frame silently (no event): HUNT, chip register cleared. `o_clk` keeps running.

## Timing
- `o_clk` starts low after reset release and rises `CLK_DIV`/2 `clk` cycles later.
- Event latency: `o_ev_sig` rises in the `clk` cycle after the buffer write of the completing byte. Byte 0 is therefore readable when PHR is seen, and all bytes are readable when END is seen.
- Byte time: 16·`SPC`·`CLK_DIV` `clk` cycles (512 at defaults).
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). No END or ERR is emitted.
- An SFD arriving inside a payload is treated as payload data; no resynchronisation occurs until HUNT.

## Structure
- `rx_pkg`:
  - Event codes (`RX_EVENT_NONE/SFD/PHR/END/ERR`).
  - SFD constant 0xA7.
  - Buffer depth 128.
- Sub-module `rx_chip_dec`: sample divider, slicer, phase tracking, chip output with a valid strobe.
- The top level holds the framing FSM (HUNT, PHR, PAYLOAD) and the buffer.
- The power-on reset generator is a separate block and is out of scope.

## Test plan
- Reset release with `i_enable` = 1 and samples constant at 0 → `o_clk` period 8, no events.
- Preamble 0x55×4, SFD 0xA7, PHR 0x03, payload 11 22 33 → events SFD, PHR, END in order; buffer[0..3] = 03 11 22 33 read with zero latency.
- Frame with `len` = 127 of incrementing bytes → END; buffer[127] = 0x7E (127th byte, 0-based 0x7E).
- Chip pair 11 injected in the second payload byte → ERR, no END; the next clean frame is received correctly.
- PHR 0x00 → ERR after SFD; no PHR event.
- `i_enable` dropped mid-payload then restored before a fresh frame → no event for the aborted frame; the new frame produces SFD, PHR, END.
